// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED sequence player: bus addresses,
// colour codes, playback states and status-word bit positions.
package led_seq_pkg;

    localparam logic [11:0] ADDR_LED  = 12'd6;
    localparam logic [11:0] ADDR_PUSH = 12'd8;
    localparam logic [11:0] ADDR_CTRL = 12'd9;
    localparam logic [11:0] ADDR_STAT = 12'd10;
    localparam logic [11:0] ADDR_TIME = 12'd11;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        COL_RED    = 2'b00,
        COL_BLUE   = 2'b01,
        COL_GREEN  = 2'b10,
        COL_YELLOW = 2'b11
    } colour_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;

    // LED vector order is {yellow, green, blue, red}
    function automatic logic [3:0] colour_onehot(input colour_t c);
        logic [3:0] oh;
        case (c)
            COL_RED:    oh = 4'b0001;
            COL_BLUE:   oh = 4'b0010;
            COL_GREEN:  oh = 4'b0100;
            COL_YELLOW: oh = 4'b1000;
            default:    oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/led_sequence_player_seq_timer.sv
// seq_timer: loadable down-counter that stops at zero and flags it; one
// instance times both the lit and the dark phase of each step.
module seq_timer
    import led_seq_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement until zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/led_sequence_player.sv
// Memory-mapped colour-sequence store and LED playback engine.
// Optional run-time timing register at address 11: LED_SEQ_TIMING_REG_EN.
module led_sequence_player
    import led_seq_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES = 12_500_000,
    parameter int CNT_W      = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [11:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [3:0]  led_out,
    output logic        busy,
    output logic        done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = IDX_W + 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             man_on_q, man_on_d;
    colour_t          man_col_q, man_col_d;
    colour_t          buf_q [DEPTH];
    colour_t          buf_d [DEPTH];
    logic [3:0]       led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      rd_q, rd_d;

    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_zero_s;
    logic [CNT_W-1:0] on_len_s;
    logic [CNT_W-1:0] gap_len_s;
    logic             full_s;
    logic             clr_s;
    logic             start_s;
    logic             wr_led_s;
    logic             wr_push_s;
    logic [31:0]      status_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign clr_s     = wr_en && (addr == ADDR_CTRL) && wr_data[1];
    assign start_s   = wr_en && (addr == ADDR_CTRL) && wr_data[0] && !wr_data[1];
    assign wr_led_s  = wr_en && (addr == ADDR_LED);
    assign wr_push_s = wr_en && (addr == ADDR_PUSH);

`ifdef LED_SEQ_TIMING_REG_EN
    logic [CNT_W-1:0] on_cyc_q, on_cyc_d;
    logic [CNT_W-1:0] gap_cyc_q, gap_cyc_d;

    // Timing register written in 1024-cycle units; picked up at the next timer load
    always_comb begin
        on_cyc_d  = on_cyc_q;
        gap_cyc_d = gap_cyc_q;
        if (wr_en && (addr == ADDR_TIME)) begin
            on_cyc_d  = CNT_W'({wr_data[15:0], 10'd0});
            gap_cyc_d = CNT_W'({wr_data[31:16], 10'd0});
        end else begin
            on_cyc_d  = on_cyc_q;
            gap_cyc_d = gap_cyc_q;
        end
    end

    // Timing register storage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            on_cyc_q  <= CNT_W'(ON_CYCLES);
            gap_cyc_q <= CNT_W'(GAP_CYCLES);
        end else begin
            on_cyc_q  <= on_cyc_d;
            gap_cyc_q <= gap_cyc_d;
        end
    end

    assign on_len_s  = on_cyc_q - {{(CNT_W-1){1'b0}}, 1'b1};
    assign gap_len_s = gap_cyc_q - {{(CNT_W-1){1'b0}}, 1'b1};
`else
    assign on_len_s  = CNT_W'(ON_CYCLES - 1);
    assign gap_len_s = CNT_W'(GAP_CYCLES - 1);
`endif

    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Bus writes, buffer append and playback state machine
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        man_on_d   = man_on_q;
        man_col_d  = man_col_q;
        buf_d      = buf_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = on_len_s;
        if (clr_s) begin
            count_d  = {CW{1'b0}};
            ovf_d    = 1'b0;
            man_on_d = 1'b0;
            state_d  = IDLE;
        end else begin
            if (wr_push_s) begin
                if ((state_q != IDLE) || full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    buf_d[count_q[IDX_W-1:0]] = colour_t'(wr_data[1:0]);
                    count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                ovf_d = ovf_q;
            end
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        man_on_d = 1'b0;
                        if (count_q == {CW{1'b0}}) begin
                            state_d = DONE;
                        end else begin
                            state_d    = ON;
                            idx_d      = {IDX_W{1'b0}};
                            tmr_load_s = 1'b1;
                            tmr_val_s  = on_len_s;
                        end
                    end else if (wr_led_s) begin
                        man_on_d  = wr_data[0];
                        man_col_d = colour_t'(wr_data[2:1]);
                    end else begin
                        state_d = IDLE;
                    end
                end
                ON: begin
                    if (tmr_zero_s) begin
                        state_d    = GAP;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = gap_len_s;
                    end else begin
                        state_d = ON;
                    end
                end
                GAP: begin
                    if (!tmr_zero_s) begin
                        state_d = GAP;
                    end else if (({1'b0, idx_q} + {{(CW-1){1'b0}}, 1'b1}) < count_q) begin
                        state_d    = ON;
                        idx_d      = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        tmr_load_s = 1'b1;
                        tmr_val_s  = on_len_s;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from next-state so they line up with the state register
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        case (state_d)
            ON:      led_d = colour_onehot(buf_q[idx_d]);
            IDLE:    led_d = man_on_d ? colour_onehot(man_col_d) : 4'b0000;
            default: led_d = 4'b0000;
        endcase
        status_s = 32'd0;
        status_s[STAT_BUSY] = busy_q;
        status_s[STAT_FULL] = full_s;
        status_s[STAT_OVF]  = ovf_q;
        status_s[STAT_CNT_LSB +: 8] = 8'(count_q);
        if (addr == ADDR_STAT) begin
            rd_d = status_s;
        end else begin
            rd_d = 32'd0;
        end
    end

    // State, control and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= {IDX_W{1'b0}};
            count_q   <= {CW{1'b0}};
            ovf_q     <= 1'b0;
            man_on_q  <= 1'b0;
            man_col_q <= COL_RED;
            led_q     <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= COL_RED;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            man_on_q  <= man_on_d;
            man_col_q <= man_col_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            buf_q     <= buf_d;
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_q;

endmodule

// File: doc/led_sequence_player.md
# led_sequence_player

Memory-mapped controller that stores the game's colour sequence and replays it on the four LEDs with fixed on/gap timing, freeing the processor from software delay loops. It sits beside the RAM on the processor's data-memory bus. It arbitrates LED ownership between direct processor writes and autonomous playback.

## Interface
Parameters:
- DEPTH, 32: sequence buffer entries (power of two).
- ON_CYCLES, 25_000_000: LED on-time per step, in clocks (0.5 s at 50 MHz).
- GAP_CYCLES, 12_500_000: dark time after each step, in clocks.
- CNT_W, 26: timer width; must hold max(ON_CYCLES, GAP_CYCLES).

Ports:
- clock  in  1  system clock (50 MHz domain)
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  data-memory write strobe
- addr  in  12  data-memory address (addr[11:0])
- wr_data  in  32  data-memory write data
- rd_data  out  32  status word, registered
- led_out  out  4  {yellow, green, blue, red}, at most one bit high
- busy  out  1  playback in progress
- done  out  1  one-cycle pulse at end of playback

## Operation
- Colour code: 00 red, 01 blue, 10 green, 11 yellow.
- Address map:
  - 6: manual LED. Colour is wr_data[2:1]; on/off is wr_data[0].
  - 8: append wr_data[1:0] at index count.
  - 9: control. wr_data[0] starts playback; wr_data[1] clears.
  - 10: status.
- Status word: rd_data[0] = busy, [1] = full, [2] = overflow, [15:8] = count, all other bits zero.
- Buffer is not a FIFO. Playback reads indices 0..count-1 and does not consume entries, so each round replays and then appends one.
- full = (count == DEPTH).
- Append when full: ignored, sets the sticky overflow flag.
- Append while busy: ignored, sets overflow.
- Clear: count <= 0, overflow <= 0, manual latch off. It also aborts playback: state goes to IDLE, led_out goes to 0, and no done pulse is issued.
- Clear and start in the same write: clear wins.
- States:
  - IDLE: on start, go to ON with idx = 0 and timer = ON_CYCLES-1, and turn the manual latch off. If count == 0, go to DONE instead.
  - ON: led_out is the one-hot of buf[idx]. When timer == 0, go to GAP with timer = GAP_CYCLES-1.
  - GAP: led_out = 0. When timer == 0, go to ON with idx+1 if idx+1 < count; otherwise go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- Start while busy: ignored.
- Manual writes while busy: ignored.
- Manual latch drives led_out only in IDLE.
- busy = (state != IDLE).

## Timing
- Reset values: all state registers, count, idx, timer, overflow, manual latch, rd_data, busy and done are 0. led_out is 4'b0000 and state is IDLE.
- Writes take effect at the rising edge where wr_en is high.
- Start written at edge N:
  - busy and the first LED are high from N+1.
  - Each step lasts exactly ON_CYCLES clocks lit, then GAP_CYCLES clocks dark.
  - DONE is the single cycle after the last gap; done = 1 in that cycle.
  - busy is high for count*(ON_CYCLES+GAP_CYCLES)+1 cycles.
- rd_data is registered from addr each cycle (one-cycle read latency, same as RAM). It is zero when addr != 10.
- Manual LED write at edge N: led_out changes at N+1.
- Reset asserted mid-playback: LEDs off immediately (asynchronous); buffer contents are don't-care.

## Configuration
- LED_SEQ_TIMING_REG_EN
  - Defined: address 11 is writable. wr_data[CNT_W-1:0] loads the on-time register and [CNT_W+15:16]... no — to fit widths, wr_data[31:16] loads gap-time in units of 1024 cycles and wr_data[15:0] loads on-time in units of 1024 cycles. Reset values equal ON_CYCLES and GAP_CYCLES. Writes while busy take effect at the next step boundary.
  - Undefined: timing is fixed to the parameters and address 11 is ignored.

## Structure
- Package led_seq_pkg holds:
  - address constants: ADDR_LED = 6, ADDR_PUSH = 8, ADDR_CTRL = 9, ADDR_STAT = 10, ADDR_TIME = 11;
  - colour typedef (2-bit enum);
  - state enum {IDLE, ON, GAP, DONE};
  - status bit-position constants.
- One sub-module, seq_timer: loadable CNT_W down-counter with a zero flag. It is shared by the ON and GAP states.

## Test plan
Benches use ON_CYCLES = 4, GAP_CYCLES = 2, DEPTH = 4.
- Playback: push red, yellow, blue, then start → led_out is 0001 ×4, 0 ×2, 1000 ×4, 0 ×2, 0010 ×4, 0 ×2. Then done is high for 1 cycle and busy is high for exactly 19 cycles.
- Empty start: start with count 0 → busy high for 1 cycle together with done, led_out stays 0.
- Full buffer: 5 pushes → status reads count = 4, full = 1, overflow = 1. Clear → status reads 0.
- Abort: clear during the second ON step → led_out = 0 and busy = 0 next cycle, done never pulses, count = 0.
- Arbitration: write 0x5 to address 6 → led_out = 0100 (green). Then start → manual latch dropped and sequence LEDs shown. A manual write during playback is ignored.
- Reset mid-step: assert reset during ON → led_out, busy and rd_data are 0 immediately. After release, status reads 0.
